// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared constants, types and helpers for the GPR writeback arbiter.
package gpr_wb_arbiter_pkg;

  localparam int GPR_AW = 5;
  localparam int GPR_DW = 32;
  localparam logic [GPR_AW-1:0] GPR_ZERO = 5'd0;

  // One pending writeback: destination register and the value to write.
  typedef struct packed {
    logic [GPR_AW-1:0] sel;
    logic [GPR_DW-1:0] data;
  } wb_req_t;

  // One-hot decode of a register select; $0 never shows up in the mask.
  function automatic logic [31:0] onehot32(input logic [GPR_AW-1:0] sel);
    logic [31:0] m;
    m = 32'd0;
    if (sel != GPR_ZERO) m[sel] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Bundle of the writeback-source request bus and the GPR write port.
// The master side is the pipeline (sources plus the GPR file/decode);
// the slave side is the arbiter.
interface gpr_wb_arbiter_if
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DW    = GPR_DW,
  parameter int AW    = GPR_AW
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_sel;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                WE;
  logic [AW-1:0]       WeSel;
  logic [DW-1:0]       WData;
  logic [31:0]         pend_mask;

  modport master (
    output req_valid, req_sel, req_data,
    input  req_ready, WE, WeSel, WData, pend_mask
  );

  modport slave (
    input  req_valid, req_sel, req_data,
    output req_ready, WE, WeSel, WData, pend_mask
  );
endinterface

// File: rtl/gpr_wb_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer one past the winner when the grant is consumed.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // Search from ptr upwards (wrapping); walking backwards lets the closest
  // candidate overwrite farther ones, so no early exit is needed.
  always_comb begin
    int cand;
    cand       = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr_q) + off;
      if (cand >= N) cand = cand - N;
      if (req[IW'(cand)]) begin
        any     = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (adv && any) ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port between several writeback sources.
// Each source owns a one-entry holding register; a round-robin arbiter
// drains one entry per cycle into the registered WE/WeSel/WData port, and
// pend_mask exposes every destination still in flight so decode can stall.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DW    = GPR_DW,
  parameter int AW    = GPR_AW
) (
  input  logic             clk,
  input  logic             rst,
  gpr_wb_arbiter_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] hold_v;
  logic [AW-1:0]    hold_sel  [N_REQ];
  logic [DW-1:0]    hold_data [N_REQ];
  logic [N_REQ-1:0] ready;

  logic [N_REQ-1:0] gnt_onehot;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;

  logic             we_q;
  logic [AW-1:0]    we_sel_q;
  logic [DW-1:0]    wdata_q;
  logic [31:0]      pend_mask;

  // Ready depends only on registered state and reset, never on valid.
  assign ready         = ~hold_v & {N_REQ{~rst}};
  assign bus.req_ready = ready;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_src
    logic          v_q;
    logic [AW-1:0] sel_q;
    logic [DW-1:0] data_q;
    logic [AW-1:0] in_sel;
    logic [DW-1:0] in_data;
    logic          accept;

    assign in_sel  = bus.req_sel[gi*AW +: AW];
    assign in_data = bus.req_data[gi*DW +: DW];
    assign accept  = bus.req_valid[gi] & ready[gi];

    // Holding entry: load on accept (writes to $0 are swallowed), clear
    // when granted. Grant and accept never coincide since ready=~v_q.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (gnt_onehot[gi]) begin
        v_q <= 1'b0;
      end else if (accept && (in_sel != '0)) begin
        v_q    <= 1'b1;
        sel_q  <= in_sel;
        data_q <= in_data;
      end
    end

    assign hold_v[gi]    = v_q;
    assign hold_sel[gi]  = sel_q;
    assign hold_data[gi] = data_q;
  end

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (hold_v),
    .adv        (1'b1),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // GPR write port: pulse WE for the granted entry; select/data keep their
  // last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      we_sel_q <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= gnt_any;
      if (gnt_any) begin
        we_sel_q <= hold_sel[gnt_idx];
        wdata_q  <= hold_data[gnt_idx];
      end
    end
  end

  // In-flight destinations: every valid holding entry plus the write now
  // on the port.
  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (hold_v[i]) pend_mask = pend_mask | onehot32(GPR_AW'(hold_sel[i]));
    end
    if (we_q) pend_mask = pend_mask | onehot32(GPR_AW'(we_sel_q));
  end

  assign bus.WE        = we_q;
  assign bus.WeSel     = we_sel_q;
  assign bus.WData     = wdata_q;
  assign bus.pend_mask = pend_mask;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with a scoreboard of accepted writes.
module tb_gpr_wb_arbiter;
  import gpr_wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpr_wb_arbiter_if #(.N_REQ(N), .DW(DW), .AW(AW)) bus ();

  gpr_wb_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  wb_req_t sb[$];
  int we_log[$];
  int we_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input bit v, input logic [4:0] sel, input logic [31:0] data);
    bus.req_valid[i]         = v;
    bus.req_sel[i*AW +: AW]  = sel;
    bus.req_data[i*DW +: DW] = data;
  endtask

  // One clock: log accepts (push expectations), advance, then check any
  // port write against the scoreboard.
  task automatic step();
    bit was_rst;
    was_rst = rst;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i] && bus.req_sel[i*AW +: AW] != 5'd0) begin
        wb_req_t e;
        e.sel  = bus.req_sel[i*AW +: AW];
        e.data = bus.req_data[i*DW +: DW];
        sb.push_back(e);
        $display("accept cyc=%0d src=%0d sel=%0d data=%h", cyc, i, e.sel, e.data);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) sb.delete();
    if (bus.WE === 1'b1) begin
      int hit;
      hit = -1;
      foreach (sb[j]) begin
        if (hit < 0 && sb[j].sel === bus.WeSel && sb[j].data === bus.WData) hit = j;
      end
      $display("write  cyc=%0d sel=%0d data=%h", cyc, bus.WeSel, bus.WData);
      chk("sb_match", 64'(hit >= 0), 64'd1);
      if (hit >= 0) sb.delete(hit);
      we_log.push_back(int'(bus.WeSel));
      we_cyc.push_back(cyc);
    end
  endtask

  initial begin
    logic [4:0] b2b_sel [3];
    int idx;
    bit acc;

    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.req_data  = '0;

    // Reset held for two cycles.
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_we", 64'(bus.WE), 64'd0);
      chk("rst_wesel", 64'(bus.WeSel), 64'd0);
      chk("rst_wdata", 64'(bus.WData), 64'd0);
      chk("rst_pend", 64'(bus.pend_mask), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'h7);

    // Contention with pointer at 0: order 1,2,3.
    we_log.delete(); we_cyc.delete();
    drive(0, 1'b1, 5'd1, 32'hA000_0001);
    drive(1, 1'b1, 5'd2, 32'hA000_0002);
    drive(2, 1'b1, 5'd3, 32'hA000_0003);
    step();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 5'd0, 32'd0);
    chk("contA_pend", 64'(bus.pend_mask), 64'h0000_000E);
    chk("contA_we0", 64'(bus.WE), 64'd0);
    for (int k = 0; k < 3; k++) step();
    chk("contA_cnt", 64'(we_log.size()), 64'd3);
    chk("contA_w0", 64'(we_log[0]), 64'd1);
    chk("contA_w1", 64'(we_log[1]), 64'd2);
    chk("contA_w2", 64'(we_log[2]), 64'd3);
    chk("contA_back2back", 64'(we_cyc[2] - we_cyc[0]), 64'd2);
    step();
    chk("contA_idle_we", 64'(bus.WE), 64'd0);
    chk("contA_idle_pend", 64'(bus.pend_mask), 64'd0);

    // Single write from source 1 to r9.
    we_log.delete(); we_cyc.delete();
    drive(1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    step();
    drive(1, 1'b0, 5'd0, 32'd0);
    chk("single_pend_held", 64'(bus.pend_mask), 64'h0000_0200);
    chk("single_ready_held", 64'(bus.req_ready), 64'h5);
    chk("single_we_early", 64'(bus.WE), 64'd0);
    step();
    chk("single_we", 64'(bus.WE), 64'd1);
    chk("single_wesel", 64'(bus.WeSel), 64'd9);
    chk("single_wdata", 64'(bus.WData), 64'hDEAD_BEEF);
    chk("single_pend_port", 64'(bus.pend_mask), 64'h0000_0200);
    chk("single_ready_free", 64'(bus.req_ready), 64'h7);
    step();
    chk("single_pend_done", 64'(bus.pend_mask), 64'd0);
    chk("single_we_done", 64'(bus.WE), 64'd0);

    // Contention with pointer at 2: order 3,1,2.
    we_log.delete(); we_cyc.delete();
    drive(0, 1'b1, 5'd1, 32'hB000_0001);
    drive(1, 1'b1, 5'd2, 32'hB000_0002);
    drive(2, 1'b1, 5'd3, 32'hB000_0003);
    step();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) step();
    chk("contB_cnt", 64'(we_log.size()), 64'd3);
    chk("contB_w0", 64'(we_log[0]), 64'd3);
    chk("contB_w1", 64'(we_log[1]), 64'd1);
    chk("contB_w2", 64'(we_log[2]), 64'd2);

    // Back-to-back on source 0: ready toggles, writes 2 cycles apart.
    we_log.delete(); we_cyc.delete();
    b2b_sel[0] = 5'd4; b2b_sel[1] = 5'd5; b2b_sel[2] = 5'd6;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      chk("b2b_ready", 64'(bus.req_ready[0]), 64'((c % 2) == 0));
      if (idx < 3) drive(0, 1'b1, b2b_sel[idx], 32'hC000_0000 + 32'(idx));
      else         drive(0, 1'b0, 5'd0, 32'd0);
      acc = bus.req_valid[0] && bus.req_ready[0];
      step();
      if (acc) idx++;
    end
    drive(0, 1'b0, 5'd0, 32'd0);
    chk("b2b_cnt", 64'(we_log.size()), 64'd3);
    chk("b2b_w0", 64'(we_log[0]), 64'd4);
    chk("b2b_w1", 64'(we_log[1]), 64'd5);
    chk("b2b_w2", 64'(we_log[2]), 64'd6);
    chk("b2b_gap01", 64'(we_cyc[1] - we_cyc[0]), 64'd2);
    chk("b2b_gap12", 64'(we_cyc[2] - we_cyc[1]), 64'd2);
    step();
    chk("b2b_idle_we", 64'(bus.WE), 64'd0);

    // Write to $0 is consumed and dropped.
    we_log.delete(); we_cyc.delete();
    chk("zero_ready_before", 64'(bus.req_ready[2]), 64'd1);
    drive(2, 1'b1, 5'd0, 32'h0000_1234);
    step();
    drive(2, 1'b0, 5'd0, 32'd0);
    chk("zero_ready_after", 64'(bus.req_ready), 64'h7);
    chk("zero_pend", 64'(bus.pend_mask), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("zero_pend_later", 64'(bus.pend_mask), 64'd0);
    end
    chk("zero_no_write", 64'(we_log.size()), 64'd0);

    // Reset while all three sources hold entries.
    we_log.delete(); we_cyc.delete();
    drive(0, 1'b1, 5'd1, 32'hD000_0001);
    drive(1, 1'b1, 5'd2, 32'hD000_0002);
    drive(2, 1'b1, 5'd3, 32'hD000_0003);
    step();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 5'd0, 32'd0);
    chk("mid_pend_held", 64'(bus.pend_mask), 64'h0000_000E);
    rst = 1'b1;
    step();
    chk("mid_we", 64'(bus.WE), 64'd0);
    chk("mid_pend", 64'(bus.pend_mask), 64'd0);
    chk("mid_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_no_write", 64'(we_log.size()), 64'd0);
    chk("mid_pend_after", 64'(bus.pend_mask), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
